// File: rtl/dram_bus_arbiter_if.sv
// Cache-side and DRAM-bus-side signal bundle for dram_bus_arbiter.
// The master modport is the arbiter's view; slave is the surrounding caches and memory.
interface dram_bus_arbiter_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned BLOCK_SIZE = 4
);
  logic                                  i_req;
  logic [ADDR_W-1:0]                     i_addr;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0]     i_rdata;
  logic                                  i_ack;
  logic                                  d_req;
  logic                                  d_we;
  logic [ADDR_W-1:0]                     d_addr;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0]     d_wdata;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0]     d_rdata;
  logic                                  d_ack;
  logic [ADDR_W-1:0]                     bus_address_to_mem;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0]     bus_data_to_mem;
  logic                                  bus_read_enable;
  logic                                  bus_write_enable;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0]     bus_data_from_mem;
  logic                                  acknowledge_from_mem;
  logic                                  bus_error;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           bus_data_from_mem, acknowledge_from_mem,
    output i_rdata, i_ack, d_rdata, d_ack,
           bus_address_to_mem, bus_data_to_mem, bus_read_enable, bus_write_enable, bus_error
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           bus_data_from_mem, acknowledge_from_mem,
    input  i_rdata, i_ack, d_rdata, d_ack,
           bus_address_to_mem, bus_data_to_mem, bus_read_enable, bus_write_enable, bus_error
  );
endinterface

// File: rtl/dram_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one block-wide DRAM bus between I-cache and D-cache,
// with a watchdog that abandons transfers the memory never acknowledges.
module dram_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned BLOCK_SIZE = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic               clk,
  input logic               reset,
  dram_bus_arbiter_if.master bus
);

  localparam int unsigned WdogW = 16;

  typedef logic [BLOCK_SIZE-1:0][WORD_W-1:0] block_t;
  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  block_t            wdata_q, wdata_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  block_t            i_rdata_q, i_rdata_d;
  block_t            d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    re_d      = re_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = err_q;
    wdog_d    = wdog_q;

    unique case (state_q)
      StIdle: begin
        // On a tie the master that did not win last time gets the bus.
        if (bus.i_req && (!bus.d_req || last_d_q)) begin
          state_d  = StBusyI;
          addr_d   = bus.i_addr;
          re_d     = 1'b1;
          we_d     = 1'b0;
          last_d_d = 1'b0;
          wdog_d   = '0;
        end else if (bus.d_req) begin
          state_d  = StBusyD;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
          re_d     = !bus.d_we;
          we_d     = bus.d_we;
          last_d_d = 1'b1;
          wdog_d   = '0;
        end
      end
      StBusyI, StBusyD: begin
        if (bus.acknowledge_from_mem) begin
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
          if (state_q == StBusyI) begin
            i_rdata_d = bus.bus_data_from_mem;
            i_ack_d   = 1'b1;
          end else begin
            if (re_q) d_rdata_d = bus.bus_data_from_mem;
            d_ack_d = 1'b1;
          end
        end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
          // Abandon the transfer silently; the requester stays pending and is re-arbitrated.
          re_d    = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      re_q      <= re_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
    end
  end

  assign bus.bus_address_to_mem = addr_q;
  assign bus.bus_data_to_mem    = wdata_q;
  assign bus.bus_read_enable    = re_q;
  assign bus.bus_write_enable   = we_q;
  assign bus.i_rdata            = i_rdata_q;
  assign bus.d_rdata            = d_rdata_q;
  assign bus.i_ack              = i_ack_q;
  assign bus.d_ack              = d_ack_q;
  assign bus.bus_error          = err_q;

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Directed bench for dram_bus_arbiter: reads, writes, fairness, spurious ack, watchdog, reset abort.
module tb_dram_bus_arbiter;

  typedef logic [3:0][31:0] block_t;

  localparam block_t RBLK1 = {32'hA1A1_0001, 32'hA1A1_0002, 32'hA1A1_0003, 32'hA1A1_0004};
  localparam block_t RBLK2 = {32'hB2B2_0001, 32'hB2B2_0002, 32'hB2B2_0003, 32'hB2B2_0004};
  localparam block_t RBLK3 = {32'hC3C3_0001, 32'hC3C3_0002, 32'hC3C3_0003, 32'hC3C3_0004};
  localparam block_t RBLK4 = {32'hD4D4_0001, 32'hD4D4_0002, 32'hD4D4_0003, 32'hD4D4_0004};
  localparam block_t RBLK5 = {32'hE5E5_0001, 32'hE5E5_0002, 32'hE5E5_0003, 32'hE5E5_0004};
  localparam block_t WBLK  = {32'd1, 32'd2, 32'd3, 32'd4};

  logic clk;
  logic reset;
  int   total;
  int   passed;

  dram_bus_arbiter_if #(.ADDR_W(32), .WORD_W(32), .BLOCK_SIZE(4)) bus_if ();

  dram_bus_arbiter #(
    .ADDR_W    (32),
    .WORD_W    (32),
    .BLOCK_SIZE(4),
    .TIMEOUT   (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one transfer whose grant happens at the next posedge; memory acks lat cycles after
  // enable. Observations are sampled on negedges; returns in the IDLE cycle after DONE.
  task automatic serve(input int lat, output int re_n, output int we_n, output int ia_n,
                       output int da_n, output int ack_at, output logic [31:0] addr_seen,
                       output block_t wd_seen, output bit gap_low);
    re_n = 0; we_n = 0; ia_n = 0; da_n = 0; ack_at = 0;
    addr_seen = '0; wd_seen = '0; gap_low = 1'b0;
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      if (bus_if.bus_read_enable) re_n++;
      if (bus_if.bus_write_enable) we_n++;
      if (bus_if.bus_read_enable || bus_if.bus_write_enable) begin
        addr_seen = bus_if.bus_address_to_mem;
        wd_seen   = bus_if.bus_data_to_mem;
      end
      if (bus_if.i_ack) begin ia_n++; if (ack_at == 0) ack_at = c; end
      if (bus_if.d_ack) begin da_n++; if (ack_at == 0) ack_at = c; end
      if (c == lat + 1) gap_low = !bus_if.bus_read_enable && !bus_if.bus_write_enable;
      bus_if.acknowledge_from_mem = (c == lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.i_req = 0; bus_if.i_addr = '0; bus_if.d_req = 0; bus_if.d_we = 0;
    bus_if.d_addr = '0; bus_if.d_wdata = '0; bus_if.bus_data_from_mem = '0;
    bus_if.acknowledge_from_mem = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus_if.bus_read_enable, bus_if.bus_write_enable, bus_if.i_ack, bus_if.d_ack,
         bus_if.bus_error} !== 5'b0) begin
      $display("FAIL reset_ctrl: got %b expected 00000", {bus_if.bus_read_enable,
               bus_if.bus_write_enable, bus_if.i_ack, bus_if.d_ack, bus_if.bus_error});
    end else passed++;
    total++;
    if ({bus_if.i_rdata, bus_if.d_rdata, bus_if.bus_address_to_mem} !== '0) begin
      $display("FAIL reset_data: got %h/%h/%h expected 0", bus_if.i_rdata, bus_if.d_rdata,
               bus_if.bus_address_to_mem);
    end else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus_if.bus_read_enable !== 1'b0 || bus_if.bus_write_enable !== 1'b0) begin
      $display("FAIL idle_after_reset: got re=%b we=%b expected 0 0", bus_if.bus_read_enable,
               bus_if.bus_write_enable);
    end else passed++;
  endtask

  task automatic test_read();
    int re_n, we_n, ia_n, da_n, ack_at;
    logic [31:0] a;
    block_t wd;
    bit gap;
    bus_if.i_req = 1; bus_if.i_addr = 32'h100; bus_if.bus_data_from_mem = RBLK1;
    serve(5, re_n, we_n, ia_n, da_n, ack_at, a, wd, gap);
    bus_if.i_req = 0;
    total++;
    if (re_n !== 5 || we_n !== 0) begin
      $display("FAIL read_enable_cycles: got re=%0d we=%0d expected 5 0", re_n, we_n);
    end else passed++;
    total++;
    if (a !== 32'h100) $display("FAIL read_addr: got %h expected 100", a);
    else passed++;
    total++;
    if (ia_n !== 1 || da_n !== 0 || ack_at !== 6) begin
      $display("FAIL read_ack: got i=%0d d=%0d at=%0d expected 1 0 6", ia_n, da_n, ack_at);
    end else passed++;
    total++;
    if (bus_if.i_rdata !== RBLK1) begin
      $display("FAIL read_data: got %h expected %h", bus_if.i_rdata, RBLK1);
    end else passed++;
  endtask

  task automatic test_write();
    int re_n, we_n, ia_n, da_n, ack_at;
    logic [31:0] a;
    block_t wd;
    bit gap;
    bus_if.d_req = 1; bus_if.d_we = 1; bus_if.d_addr = 32'h2040; bus_if.d_wdata = WBLK;
    bus_if.bus_data_from_mem = RBLK2;
    serve(3, re_n, we_n, ia_n, da_n, ack_at, a, wd, gap);
    bus_if.d_req = 0; bus_if.d_we = 0;
    total++;
    if (we_n !== 3 || re_n !== 0) begin
      $display("FAIL write_enable_cycles: got we=%0d re=%0d expected 3 0", we_n, re_n);
    end else passed++;
    total++;
    if (a !== 32'h2040 || wd !== WBLK) begin
      $display("FAIL write_bus: got %h/%h expected 2040/%h", a, wd, WBLK);
    end else passed++;
    total++;
    if (da_n !== 1 || ia_n !== 0) begin
      $display("FAIL write_ack: got d=%0d i=%0d expected 1 0", da_n, ia_n);
    end else passed++;
    total++;
    if (bus_if.d_rdata !== '0 || bus_if.i_rdata !== RBLK1) begin
      $display("FAIL write_rdata: got %h/%h expected 0/%h", bus_if.d_rdata, bus_if.i_rdata,
               RBLK1);
    end else passed++;
  endtask

  task automatic test_fairness();
    int re_n, we_n, ia_n, da_n, ack_at;
    logic [31:0] a;
    block_t wd;
    bit gap;
    logic [31:0] exp_a;
    bus_if.i_req = 1; bus_if.i_addr = 32'h111;
    bus_if.d_req = 1; bus_if.d_we = 0; bus_if.d_addr = 32'h222;
    bus_if.bus_data_from_mem = RBLK2;
    for (int t = 0; t < 4; t++) begin
      serve(3, re_n, we_n, ia_n, da_n, ack_at, a, wd, gap);
      exp_a = (t % 2 == 0) ? 32'h111 : 32'h222;
      total++;
      if (a !== exp_a || re_n !== 3) begin
        $display("FAIL fair_grant%0d: got addr=%h re=%0d expected %h 3", t, a, re_n, exp_a);
      end else passed++;
      total++;
      if (!gap) $display("FAIL fair_gap%0d: got enable high expected low in DONE", t);
      else passed++;
    end
    bus_if.i_req = 0; bus_if.d_req = 0;
    total++;
    if (bus_if.d_rdata !== RBLK2 || bus_if.i_rdata !== RBLK2) begin
      $display("FAIL fair_rdata: got %h/%h expected %h", bus_if.i_rdata, bus_if.d_rdata, RBLK2);
    end else passed++;
  endtask

  task automatic test_spurious_ack();
    int acks, ens;
    acks = 0; ens = 0;
    @(negedge clk);
    bus_if.bus_data_from_mem = RBLK3;
    bus_if.acknowledge_from_mem = 1;
    @(negedge clk);
    bus_if.acknowledge_from_mem = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_if.i_ack || bus_if.d_ack) acks++;
      if (bus_if.bus_read_enable || bus_if.bus_write_enable) ens++;
    end
    total++;
    if (acks !== 0 || ens !== 0) begin
      $display("FAIL spurious_ack: got acks=%0d enables=%0d expected 0 0", acks, ens);
    end else passed++;
    total++;
    if (bus_if.i_rdata !== RBLK2 || bus_if.d_rdata !== RBLK2) begin
      $display("FAIL spurious_rdata: got %h/%h expected %h", bus_if.i_rdata, bus_if.d_rdata,
               RBLK2);
    end else passed++;
  endtask

  task automatic test_timeout();
    int re_n, acks;
    logic err17;
    block_t rd18;
    re_n = 0; acks = 0; err17 = 0; rd18 = '0;
    bus_if.i_req = 1; bus_if.i_addr = 32'h300; bus_if.bus_data_from_mem = RBLK4;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (bus_if.bus_read_enable) re_n++;
      if (bus_if.i_ack || bus_if.d_ack) acks++;
      if (c == 17) err17 = bus_if.bus_error;
      if (c == 18) rd18 = bus_if.i_rdata;
    end
    total++;
    if (re_n !== 16) $display("FAIL timeout_cycles: got %0d expected 16", re_n);
    else passed++;
    total++;
    if (err17 !== 1'b1) $display("FAIL timeout_error: got %b expected 1", err17);
    else passed++;
    total++;
    if (acks !== 0 || rd18 !== RBLK2) begin
      $display("FAIL timeout_noack: got acks=%0d rdata=%h expected 0 %h", acks, rd18, RBLK2);
    end else passed++;
    @(negedge clk);
    total++;
    if (bus_if.bus_read_enable !== 1'b1 || bus_if.bus_address_to_mem !== 32'h300) begin
      $display("FAIL timeout_regrant: got re=%b addr=%h expected 1 300",
               bus_if.bus_read_enable, bus_if.bus_address_to_mem);
    end else passed++;
    bus_if.acknowledge_from_mem = 1;
    @(negedge clk);
    bus_if.acknowledge_from_mem = 0;
    total++;
    if (bus_if.i_ack !== 1'b1) $display("FAIL timeout_retry_ack: got %b expected 1", bus_if.i_ack);
    else passed++;
    @(negedge clk);
    bus_if.i_req = 0;
    total++;
    if (bus_if.i_rdata !== RBLK4 || bus_if.bus_error !== 1'b1) begin
      $display("FAIL timeout_sticky: got rdata=%h err=%b expected %h 1", bus_if.i_rdata,
               bus_if.bus_error, RBLK4);
    end else passed++;
  endtask

  task automatic test_reset_abort();
    int re_n, we_n, ia_n, da_n, ack_at;
    logic [31:0] a;
    block_t wd;
    bit gap;
    bus_if.d_req = 1; bus_if.d_we = 0; bus_if.d_addr = 32'h400;
    bus_if.bus_data_from_mem = RBLK5;
    repeat (2) @(negedge clk);
    total++;
    if (bus_if.bus_read_enable !== 1'b1) begin
      $display("FAIL abort_pre: got re=%b expected 1", bus_if.bus_read_enable);
    end else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({bus_if.bus_read_enable, bus_if.bus_write_enable, bus_if.d_ack, bus_if.bus_error,
         bus_if.i_ack} !== 5'b0) begin
      $display("FAIL abort_async: got %b expected 00000", {bus_if.bus_read_enable,
               bus_if.bus_write_enable, bus_if.d_ack, bus_if.bus_error, bus_if.i_ack});
    end else passed++;
    @(negedge clk);
    reset = 1'b0;
    bus_if.i_req = 1; bus_if.i_addr = 32'h500;
    serve(2, re_n, we_n, ia_n, da_n, ack_at, a, wd, gap);
    bus_if.i_req = 0;
    total++;
    if (a !== 32'h500 || ia_n !== 1 || da_n !== 0) begin
      $display("FAIL abort_first_i: got addr=%h i=%0d d=%0d expected 500 1 0", a, ia_n, da_n);
    end else passed++;
    serve(2, re_n, we_n, ia_n, da_n, ack_at, a, wd, gap);
    bus_if.d_req = 0;
    total++;
    if (a !== 32'h400 || da_n !== 1 || bus_if.d_rdata !== RBLK5) begin
      $display("FAIL abort_then_d: got addr=%h d=%0d rdata=%h expected 400 1 %h", a, da_n,
               bus_if.d_rdata, RBLK5);
    end else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_read();
    test_write();
    test_fairness();
    test_spurious_ack();
    test_timeout();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dram_bus_arbiter.md
Name: dram_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the single main-memory bus interface (`dram_interface` bus side).
- Shares the block-wide DRAM bus between the instruction cache (read-only) and the data cache (read/write).
- Latches the winner's request, holds the bus enable until the memory acknowledge, then returns the block and a one-cycle ack to the winner.
- Sits between the cache controllers and the DRAM bus interface; round-robin fairness; watchdog flags hung transfers.

Parameters:
- ADDR_W, `DRAM_ADDRESS_SIZE: byte address width.
- WORD_W, `DRAM_WORD_SIZE: word width.
- BLOCK_SIZE, `DRAM_BLOCK_SIZE: words per block transfer.
- TIMEOUT, 1024: cycles allowed from bus enable to acknowledge; 16..65535 supported.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- reset, in, 1: asynchronous, active-high reset.
- i_req, in, 1: I-cache block read request; level, held until i_ack.
- i_addr, in, ADDR_W: I-cache block address.
- i_rdata, out, WORD_W x BLOCK_SIZE: block returned to I-cache.
- i_ack, out, 1: one-cycle completion pulse to I-cache.
- d_req, in, 1: D-cache request; level, held until d_ack.
- d_we, in, 1: 1 = block write, 0 = block read.
- d_addr, in, ADDR_W: D-cache block address.
- d_wdata, in, WORD_W x BLOCK_SIZE: write block.
- d_rdata, out, WORD_W x BLOCK_SIZE: block returned to D-cache (reads only).
- d_ack, out, 1: one-cycle completion pulse to D-cache.
- bus_address_to_mem, out, ADDR_W: address to the DRAM bus.
- bus_data_to_mem, out, WORD_W x BLOCK_SIZE: write block to the bus.
- bus_read_enable, out, 1: bus read strobe.
- bus_write_enable, out, 1: bus write strobe.
- bus_data_from_mem, in, WORD_W x BLOCK_SIZE: read block from the bus.
- acknowledge_from_mem, in, 1: transfer-complete from memory.
- bus_error, out, 1: sticky watchdog timeout flag.

Behaviour:
- All state is registered; no combinational path from inputs to bus outputs.
- Reset (async): state = IDLE, last_grant = D (so I wins first tie), all outputs 0 including rdata registers and bus_error, watchdog = 0.
- Reset asserted mid-transfer aborts immediately: enables drop asynchronously and no ack is issued.

FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - Requests are sampled only here.
  - Only i_req: go to BUSY_I. Only d_req: go to BUSY_D.
  - Both: grant the master other than last_grant.
  - Taking a grant latches the address, and for D also d_we and d_wdata, into the bus output registers. It also sets the matching enable and updates last_grant.
- Latency: a request seen in IDLE at edge N puts the bus enable high after edge N.
- BUSY_x:
  - Address, data and enable are held stable; requester inputs are ignored (changes after grant have no effect).
  - On the edge sampling acknowledge_from_mem = 1: enables go to 0.
  - A read latches bus_data_from_mem into i_rdata or d_rdata.
  - The matching i_ack or d_ack goes high for exactly one cycle; state goes to DONE.
- DONE:
  - One-cycle turnaround with enables low, so the DRAM sees a deasserted enable before any new transfer.
  - Then returns to IDLE.
  - The requester must drop req in the cycle after its ack; a still-high req is treated as a new request.
- Ack/data timing: ack-to-requester latency is 1 cycle after memory acknowledge. rdata stays valid and unchanged until the next read completion for that master.
- Writes: d_rdata is not updated.
- acknowledge_from_mem in IDLE or DONE is ignored.
- Minimum back-to-back period is bus latency + 2 cycles.
- Watchdog:
  - Counter clears on entry to BUSY_x and increments each BUSY cycle.
  - Reaching TIMEOUT sets bus_error (sticky until reset), drops enables, and goes to DONE without an ack or data update.
  - The requester then stays pending and is re-arbitrated.
- Fairness: with both masters continuously requesting, grants strictly alternate I, D, I, D.

Test Plan:
- Reset, then i_req with i_addr=0x100 and memory acking 5 cycles after enable -> bus_read_enable high for exactly 5 cycles with address 0x100; i_rdata = bus block; i_ack pulses once, 1 cycle after acknowledge.
- d_req with d_we=1, d_addr=0x2040, d_wdata={1,2,3,4} -> bus_write_enable high, bus_data_to_mem={1,2,3,4}; d_ack pulses once; d_rdata unchanged (0).
- i_req and d_req asserted together and held, re-asserting after each ack, for 4 transfers -> grant order I, D, I, D; a DONE cycle with both enables low between each transfer.
- Memory never acks with TIMEOUT=16 -> enable drops after 16 cycles; bus_error = 1 and stays high; no ack pulse; pending request re-granted.
- Assert reset 2 cycles into a BUSY_D read -> enables and d_ack 0 immediately; state IDLE; next grant goes to I when both request.
- Spurious acknowledge_from_mem pulse in IDLE -> no ack pulses and no rdata change.
